// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the dual-port data memory between the CPU load-store unit
// (master 0) and a secondary loader/DMA master (master 1).
// Grant and memory mux are combinational (0-cycle grant). Read data returns 1 cycle later.
// Backpressure: an ungranted master holds req and its bundle. Master 1 is forced in
// after MAX_WAIT refusals. A locked burst is capped at MAX_BURST grants.
// Ports: i_clk, i_reset (sync, active-low); per master N: req, addr/data/wren A+B
// in, gnt/rvalid/q A+B out; i_m1_lock; o_dmem_* bundle to memory, i_dmem_q_* back.
module dmem_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic [15:0] i_m0_addr_a,
  input  logic [15:0] i_m0_addr_b,
  input  logic [31:0] i_m0_data_a,
  input  logic [31:0] i_m0_data_b,
  input  logic [3:0]  i_m0_wren_a,
  input  logic [3:0]  i_m0_wren_b,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_q_a,
  output logic [31:0] o_m0_q_b,
  input  logic        i_m1_req,
  input  logic        i_m1_lock,
  input  logic [15:0] i_m1_addr_a,
  input  logic [15:0] i_m1_addr_b,
  input  logic [31:0] i_m1_data_a,
  input  logic [31:0] i_m1_data_b,
  input  logic [3:0]  i_m1_wren_a,
  input  logic [3:0]  i_m1_wren_b,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_q_a,
  output logic [31:0] o_m1_q_b,
  output logic [15:0] o_dmem_addr_a,
  output logic [15:0] o_dmem_addr_b,
  output logic [31:0] o_dmem_data_a,
  output logic [31:0] o_dmem_data_b,
  output logic [3:0]  o_dmem_wren_a,
  output logic [3:0]  o_dmem_wren_b,
  input  logic [31:0] i_dmem_q_a,
  input  logic [31:0] i_dmem_q_b
);

  localparam logic [3:0] WAIT_LIM  = 4'(MAX_WAIT);
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  typedef enum logic {ARB, LOCK} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] burst_cnt;
  logic       rd_pend;
  logic       rd_owner;

  logic gnt0, gnt1;
  logic lock_hold;
  logic m0_rd, m1_rd;
  logic ret_vld;

  assign m0_rd = ~|{i_m0_wren_a, i_m0_wren_b};
  assign m1_rd = ~|{i_m1_wren_a, i_m1_wren_b};

  // Burst continues only while master 1 keeps both req and lock and the cap is not hit.
  assign lock_hold = (state == LOCK) && i_m1_req && i_m1_lock && (burst_cnt < BURST_LIM);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_reset) begin
      if (lock_hold) begin
        gnt1 = 1'b1;
      end else if (state == LOCK) begin
        // Leaving a burst: the CPU gets this slot regardless of wait_cnt.
        if (i_m0_req)      gnt0 = 1'b1;
        else if (i_m1_req) gnt1 = 1'b1;
      end else begin
        if (i_m1_req && (!i_m0_req || wait_cnt == WAIT_LIM)) gnt1 = 1'b1;
        else if (i_m0_req)                                    gnt0 = 1'b1;
      end
    end
  end

  assign o_m0_gnt = gnt0;
  assign o_m1_gnt = gnt1;

  always_comb begin
    o_dmem_addr_a = '0;
    o_dmem_addr_b = '0;
    o_dmem_data_a = '0;
    o_dmem_data_b = '0;
    o_dmem_wren_a = '0;
    o_dmem_wren_b = '0;
    if (gnt0) begin
      o_dmem_addr_a = i_m0_addr_a;
      o_dmem_addr_b = i_m0_addr_b;
      o_dmem_data_a = i_m0_data_a;
      o_dmem_data_b = i_m0_data_b;
      o_dmem_wren_a = i_m0_wren_a;
      o_dmem_wren_b = i_m0_wren_b;
    end else if (gnt1) begin
      o_dmem_addr_a = i_m1_addr_a;
      o_dmem_addr_b = i_m1_addr_b;
      o_dmem_data_a = i_m1_data_a;
      o_dmem_data_b = i_m1_data_b;
      o_dmem_wren_a = i_m1_wren_a;
      o_dmem_wren_b = i_m1_wren_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state     <= ARB;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_owner  <= 1'b0;
    end else begin
      if (!i_m1_req || gnt1)        wait_cnt <= '0;
      else if (wait_cnt < WAIT_LIM) wait_cnt <= wait_cnt + 4'd1;

      rd_pend  <= (gnt0 && m0_rd) || (gnt1 && m1_rd);
      rd_owner <= gnt1;

      if (lock_hold) begin
        burst_cnt <= burst_cnt + 4'd1;
      end else if (gnt1 && i_m1_lock) begin
        // Fresh burst, either from ARB or re-entered right after a capped burst.
        state     <= LOCK;
        burst_cnt <= 4'd1;
      end else begin
        state     <= ARB;
        burst_cnt <= '0;
      end
    end
  end

  // Gating with i_reset drops a pending return when reset lands the cycle after a read.
  assign ret_vld     = rd_pend && i_reset;
  assign o_m0_rvalid = ret_vld && !rd_owner;
  assign o_m1_rvalid = ret_vld && rd_owner;
  assign o_m0_q_a    = o_m0_rvalid ? i_dmem_q_a : '0;
  assign o_m0_q_b    = o_m0_rvalid ? i_dmem_q_b : '0;
  assign o_m1_q_a    = o_m1_rvalid ? i_dmem_q_a : '0;
  assign o_m1_q_b    = o_m1_rvalid ? i_dmem_q_b : '0;

endmodule
